// File: rtl/fxp_addsub_acc.sv
// fxp_addsub_acc: unsigned fixed-point add/sub/accumulate with a two-stage
// valid/ready pipeline (S1 compute, S2 output).
// Build option: define FXP_SAT_EN to saturate overflowed results instead of
// wrapping modulo 2^W; ovf is reported identically either way.
module fxp_addsub_acc #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [INT_W-1:0]  a_int,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic [INT_W-1:0]  b_int,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  res_int,
  output logic [FRAC_W-1:0] res_frac,
  output logic              ovf
);

  localparam int W = INT_W + FRAC_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  op_e          op_d;
  logic [W-1:0] a_val;
  logic [W-1:0] b_val;
  logic [W-1:0] acc_q;
  logic [W:0]   r_wide;
  logic [W-1:0] r_val;
  logic         r_ovf;

  logic         s2_load;
  logic         s1_adv;
  logic         accept;

  logic         s1_valid;
  logic [W-1:0] s1_res;
  logic         s1_ovf;
  logic [W-1:0] res_q;

  assign op_d  = op_e'(op);
  assign a_val = {a_int, a_frac};
  assign b_val = {b_int, b_frac};

  // Handshake: S2 drains on out_ready, S1 moves when S2 can take its contents.
  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = rst_n && s1_adv;
  assign accept   = in_valid && in_ready;

  // Result and overflow for the beat on the input ports, computed at acceptance
  // so that the accumulator can be updated on the same edge.
  always_comb begin
    r_wide = '0;
    r_ovf  = 1'b0;
    case (op_d)
      OP_ADD: begin
        r_wide = {1'b0, a_val} + {1'b0, b_val};
        r_ovf  = r_wide[W];
      end
      OP_SUB: begin
        // Bit W of a zero-extended W+1 bit difference is the borrow (a < b).
        r_wide = {1'b0, a_val} - {1'b0, b_val};
        r_ovf  = r_wide[W];
      end
      OP_ACC: begin
        r_wide = {1'b0, acc_q} + {1'b0, a_val};
        r_ovf  = r_wide[W];
      end
      default: begin
        r_wide = '0;
        r_ovf  = 1'b0;
      end
    endcase
    r_val = r_wide[W-1:0];
`ifdef FXP_SAT_EN
    if (r_ovf) begin
      r_val = (op_d == OP_SUB) ? '0 : '1;
    end
`endif
  end

  // Accumulator follows accepted ACC/CLR beats immediately, so back-to-back
  // ACC beats chain with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      if (op_d == OP_ACC) begin
        acc_q <= r_val;
      end else if (op_d == OP_CLR) begin
        acc_q <= '0;
      end
    end
  end

  // S1: captures the computed result of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_ovf   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_res <= r_val;
        s1_ovf <= r_ovf;
      end
    end
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res_q <= s1_res;
        ovf   <= s1_ovf;
      end
    end
  end

  assign res_int  = res_q[W-1:FRAC_W];
  assign res_frac = res_q[FRAC_W-1:0];

endmodule

// File: tb/tb_fxp_addsub_acc.sv
// Self-checking bench for fxp_addsub_acc (INT_W=8, FRAC_W=4): directed
// examples plus randomized traffic against an arithmetic reference model.
module tb_fxp_addsub_acc;

  localparam int INT_W  = 8;
  localparam int FRAC_W = 4;
  localparam int W      = INT_W + FRAC_W;
  localparam longint MAXV = (64'd1 << W) - 1;
`ifdef FXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [INT_W-1:0]  a_int;
  logic [FRAC_W-1:0] a_frac;
  logic [INT_W-1:0]  b_int;
  logic [FRAC_W-1:0] b_frac;
  logic              out_valid;
  logic              out_ready;
  logic [INT_W-1:0]  res_int;
  logic [FRAC_W-1:0] res_frac;
  logic              ovf;

  fxp_addsub_acc #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a_int    (a_int),
    .a_frac   (a_frac),
    .b_int    (b_int),
    .b_frac   (b_frac),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_int  (res_int),
    .res_frac (res_frac),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint seen_q[$];
  longint model_acc;
  int     checks;
  int     errors;
  bit     held;
  longint held_res;
  bit     held_ovf;
  bit     obs_valid;
  longint obs_res;
  bit     obs_ovf;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on fixed-point values scaled by 2^FRAC_W.
  function automatic void model_push(input logic [1:0] o, input longint a, input longint b);
    exp_t e;
    longint r;
    e.ovf = 1'b0;
    case (o)
      2'd0, 2'd2: begin
        r = (o == 2'd0) ? a + b : model_acc + a;
        if (r > MAXV) begin
          e.ovf = 1'b1;
          r = SAT ? MAXV : r - (MAXV + 1);
        end
        if (o == 2'd2) model_acc = r;
      end
      2'd1: begin
        if (a < b) begin
          e.ovf = 1'b1;
          r = SAT ? 0 : a - b + MAXV + 1;
        end else begin
          r = a - b;
        end
      end
      default: begin
        r = 0;
        model_acc = 0;
      end
    endcase
    e.res = r;
    exp_q.push_back(e);
  endfunction

  // One clock: observe at the falling edge, then advance to just after the rising edge.
  task automatic cycle(output bit accepted);
    exp_t e;
    @(negedge clk);
    obs_valid = out_valid;
    obs_res   = {res_int, res_frac};
    obs_ovf   = ovf;
    if (held) begin
      check("stall_valid", out_valid, 1);
      check("stall_res", obs_res, held_res);
      check("stall_ovf", ovf, held_ovf);
    end
    check("in_ready", in_ready, (exp_q.size() == 2 && !out_ready) ? 0 : 1);
    held = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("res", obs_res, e.res);
        check("ovf", ovf, e.ovf);
        seen_q.push_back(obs_res);
      end else begin
        held     = 1'b1;
        held_res = obs_res;
        held_ovf = ovf;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) model_push(op, {a_int, a_frac}, {b_int, b_frac});
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input int ai, input int af, input int bi, input int bf);
    bit acc;
    op = o; a_int = ai[INT_W-1:0]; a_frac = af[FRAC_W-1:0];
    b_int = bi[INT_W-1:0]; b_frac = bf[FRAC_W-1:0];
    in_valid = 1'b1;
    cycle(acc);
    check("issue_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cyc;
    checks = 0; errors = 0; held = 0; model_acc = 0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; out_ready = 1'b1;
    a_int = '0; a_frac = '0; b_int = '0; b_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res", {res_int, res_frac}, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 3.5 + 2.75 = 6.25, visible two cycles after acceptance
    issue(2'd0, 3, 8, 2, 12);
    cycle(acc);
    check("lat1_valid", obs_valid, 0);
    cycle(acc);
    check("lat2_valid", obs_valid, 1);
    check("add_res", obs_res, 100);
    check("add_ovf", obs_ovf, 0);

    issue(2'd0, 255, 15, 0, 1);
    idle(2);
    check("add_ovf_res", obs_res, SAT ? 4095 : 0);
    check("add_ovf_flag", obs_ovf, 1);

    issue(2'd1, 1, 0, 2, 0);
    idle(2);
    check("sub_udf_res", obs_res, SAT ? 0 : 4080);
    check("sub_udf_flag", obs_ovf, 1);

    // CLR then four back-to-back ACC of 1.5
    issue(2'd3, 0, 0, 0, 0);
    idle(3);
    seen_q.delete();
    op = 2'd2; a_int = 8'd1; a_frac = 4'd8; b_int = 8'd77; b_frac = 4'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      check("acc_b2b_accept", acc, 1);
    end
    in_valid = 1'b0;
    idle(3);
    check("acc_count", seen_q.size(), 4);
    if (seen_q.size() == 4) begin
      check("acc0", seen_q[0], 24);
      check("acc1", seen_q[1], 48);
      check("acc2", seen_q[2], 72);
      check("acc3", seen_q[3], 96);
    end
    issue(2'd2, 0, 0, 0, 0);
    idle(2);
    check("acc_final", obs_res, 96);

    // 8 ADD beats with out_ready pattern 1,0,0,1
    seen_q.delete();
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      op = 2'd0;
      a_int = 8'($urandom); a_frac = 4'($urandom);
      b_int = 8'($urandom); b_frac = 4'($urandom);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        cyc++;
        cycle(acc);
      end
      check("stall_stream_accept", acc, 1);
    end
    in_valid = 1'b0;
    for (int t = 0; t < 12; t++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      cyc++;
      cycle(acc);
    end
    out_ready = 1'b1;
    idle(3);
    check("stall_stream_count", seen_q.size(), 8);

    // Reset with two beats in flight
    out_ready = 1'b0;
    issue(2'd0, 10, 0, 20, 0);
    issue(2'd0, 30, 0, 40, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_res", {res_int, res_frac}, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    model_acc = 0;
    held = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(2'd2, 2, 0, 0, 0);
    idle(2);
    check("post_rst_acc", obs_res, 32);
    check("post_rst_acc_ovf", obs_ovf, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op     = 2'($urandom);
      a_int  = 8'($urandom); a_frac = 4'($urandom);
      b_int  = 8'($urandom); b_frac = 4'($urandom);
      cycle(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
